// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - keypad/ALU handshake and status bundle for calc_sequencer
interface calc_sequencer_if;
  logic [3:0] key_value;
  logic       key_press;
  logic       alu_done;
  logic       alu_err;
  logic       shift_en_a;
  logic       shift_en_b;
  logic       clear_a;
  logic       clear_b;
  logic [1:0] operator;
  logic       alu_start;
  logic [2:0] state;
  logic       result_valid;
  logic       error;

  modport master (
    input  key_value, key_press, alu_done, alu_err,
    output shift_en_a, shift_en_b, clear_a, clear_b, operator,
           alu_start, state, result_valid, error
  );

  modport slave (
    output key_value, key_press, alu_done, alu_err,
    input  shift_en_a, shift_en_b, clear_a, clear_b, operator,
           alu_start, state, result_valid, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad calculator control sequencer
module calc_sequencer #(
  parameter int DIGITS  = 2,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  calc_sequencer_if.master bus
);
  localparam int         CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DMAX = CW'(DIGITS);
  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          kp_q;
  logic          shift_a_q, shift_b_q, clr_q, start_q, rv_q, err_q;
  logic          shift_a_d, shift_b_d, clr_d;

  logic key_ev, is_digit, is_clr, is_exe, is_op;

  assign key_ev   = bus.key_press & ~kp_q;
  assign is_digit = bus.key_value <= 4'h9;
  assign is_clr   = bus.key_value == 4'hA;
  assign is_exe   = bus.key_value == 4'hB;
  assign is_op    = bus.key_value >= 4'hC;

  always_comb begin
    state_d   = state_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    op_d      = op_q;
    tcnt_d    = tcnt_q;
    shift_a_d = 1'b0;
    shift_b_d = 1'b0;
    clr_d     = 1'b0;
    case (state_q)
      S_A: begin
        if (key_ev && is_digit && cnt_a_q < DMAX) begin
          shift_a_d = 1'b1;
          cnt_a_d   = cnt_a_q + CW'(1);
        end
        // Operator key codes C..F map to div..add by bit inversion.
        if (key_ev && is_op && cnt_a_q != '0) begin
          op_d    = ~bus.key_value[1:0];
          state_d = S_B;
        end
      end
      S_B: begin
        if (key_ev && is_digit && cnt_b_q < DMAX) begin
          shift_b_d = 1'b1;
          cnt_b_d   = cnt_b_q + CW'(1);
        end
        if (key_ev && is_op && cnt_b_q == '0) op_d = ~bus.key_value[1:0];
        if (key_ev && is_exe && cnt_b_q != '0) state_d = S_EXEC;
      end
      S_EXEC: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_done) begin
          state_d = bus.alu_err ? S_ERR : S_SHOW;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TMAX) state_d = S_ERR;
        end
      end
      S_SHOW, S_ERR: ;
      default: begin
        state_d = S_A;
        cnt_a_d = '0;
        cnt_b_d = '0;
        op_d    = 2'b00;
        tcnt_d  = '0;
      end
    endcase
    // Clear wins over everything, alu_done included, but not over recovery from an illegal code.
    if (key_ev && is_clr && state_q <= S_ERR) begin
      clr_d     = 1'b1;
      shift_a_d = 1'b0;
      shift_b_d = 1'b0;
      cnt_a_d   = '0;
      cnt_b_d   = '0;
      state_d   = S_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_A;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      op_q      <= 2'b00;
      tcnt_q    <= '0;
      kp_q      <= 1'b1;
      shift_a_q <= 1'b0;
      shift_b_q <= 1'b0;
      clr_q     <= 1'b0;
      start_q   <= 1'b0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      op_q      <= op_d;
      tcnt_q    <= tcnt_d;
      kp_q      <= bus.key_press;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      clr_q     <= clr_d;
      start_q   <= state_d == S_EXEC;
      rv_q      <= state_d == S_SHOW;
      err_q     <= state_d == S_ERR;
    end
  end

  assign bus.shift_en_a   = shift_a_q;
  assign bus.shift_en_b   = shift_b_q;
  assign bus.clear_a      = clr_q;
  assign bus.clear_b      = clr_q;
  assign bus.operator     = op_q;
  assign bus.alu_start    = start_q;
  assign bus.state        = state_q;
  assign bus.result_valid = rv_q;
  assign bus.error        = err_q;
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Keypad-calculator controller. It sits between the keypad scanner (key_value, key_press) and the operand shift registers and ALU. It turns key presses into one-cycle enable and clear strobes for operand A and operand B, latches the selected operator, starts the ALU, and waits for it to finish. It also tracks result and error status for the display logic.

Parameters:
DIGITS, 2, max digits accepted per operand (each digit = one shift of its register)
TIMEOUT, 64, clk cycles allowed in WAIT before forcing ERR (8-bit counter, range 1..255)

Ports:
clk  in  1  system clock (scanner clock domain)
rst_n  in  1  asynchronous active-low reset
key_value  in  4  decoded key code from scanner
key_press  in  1  level, high while a key is held
alu_done  in  1  ALU completion pulse/level
alu_err  in  1  ALU error (e.g. divide by zero), qualified by alu_done
shift_en_a  out  1  one-cycle strobe: shift key_value into operand A
shift_en_b  out  1  one-cycle strobe: shift key_value into operand B
clear_a  out  1  one-cycle strobe: zero operand A
clear_b  out  1  one-cycle strobe: zero operand B
operator  out  2  00 add, 01 sub, 10 mul, 11 div
alu_start  out  1  one-cycle ALU start strobe
state  out  3  current FSM state (for LEDs)
result_valid  out  1  high while in SHOW
error  out  1  high while in ERR

Behaviour:
- Reset (async, rst_n=0):
  - state=A; operator=00; all strobes, result_valid and error = 0.
  - cnt_a=cnt_b=0; timeout counter=0.
  - kp_q=1, so a key held across reset release produces no event.
- Event detection: event fires on a clk edge with key_press=1 and kp_q=0. kp_q<=key_press every cycle. key_value is sampled on that same edge. Exactly one event per press.
- Key classes:
  - digit: 0x0–0x9.
  - CLR: 0xA.
  - EXE: 0xB.
  - operator keys: 0xF add, 0xE sub, 0xD mul, 0xC div.
- Output timing: all outputs are registered. A strobe caused by an event is high for exactly one cycle, in the cycle after the event edge. At most one of shift_en_a/shift_en_b/alu_start is high per cycle.
- Full clear (CLR in any state): clear_a=clear_b=1 for one cycle; cnt_a=cnt_b=0; operator unchanged; next state A. CLR has priority over every other condition in the same cycle, including alu_done.
- State A (0):
  - digit with cnt_a<DIGITS: shift_en_a, cnt_a++.
  - digit with cnt_a==DIGITS: ignored.
  - operator key with cnt_a>=1: latch operator, go to B.
  - operator key with cnt_a==0: ignored.
  - EXE: ignored.
- State B (1):
  - digit with cnt_b<DIGITS: shift_en_b, cnt_b++; excess digits ignored.
  - operator key with cnt_b==0: replaces the latched operator.
  - operator key with cnt_b>=1: ignored.
  - EXE with cnt_b>=1: go to EXEC.
  - EXE with cnt_b==0: ignored.
- State EXEC (2): alu_start=1 for one cycle; timeout counter cleared; next state WAIT unconditionally.
- State WAIT (3):
  - alu_done=1, alu_err=0: go to SHOW.
  - alu_done=1, alu_err=1: go to ERR.
  - counter reaches TIMEOUT with no alu_done: go to ERR.
  - digit, operator and EXE events: ignored.
- State SHOW (4): result_valid=1. Only CLR exits; all other keys ignored.
- State ERR (5): error=1. Only CLR exits.
- alu_done outside WAIT: ignored.
- Reset mid-operation (any state, including WAIT): immediate return to reset values. No alu_start is issued afterwards.
- Unused state codes 6/7: next state A, with outputs as in reset.

Test Plan:
- Reset release with key_press held at 1, then release and press key 0x3 → no strobe at release; exactly one shift_en_a pulse after the 0x3 press; cnt_a=1.
- Keys 1,2,7 then 0xE → shift_en_a pulses twice (third digit ignored); operator=01; state=1.
- In B: 0xD, then 4, then 0xF, then 0xB → operator=10 (the 0xF after a digit is ignored); one shift_en_b; alu_start one cycle later in EXEC; state 3.
- In WAIT: alu_done=1, alu_err=1 → state=5, error=1. Then key 0xA → clear_a=clear_b=1 for one cycle; state=0; error=0.
- In WAIT with no alu_done for TIMEOUT=64 cycles → state=5 on cycle 64.
- A CLR event in the same cycle as alu_done → state=0 (not SHOW). Separately, drop rst_n while in WAIT → all outputs 0 asynchronously; state=0.
